// File: rtl/forward_engine.sv
// rtl/forward_engine.sv - MAC learning/forwarding engine feeding per-egress VOQ write requests.
// Define FWD_AGING_EN to give every table entry an age counter driven by age_tick_i.
module forward_engine #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_W      = 12,
  parameter int TABLE_DEPTH = 16,
  parameter int AGE_LIMIT   = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        eof_i,
  input  logic [NUM_PORTS*48-1:0]     rx_mac_src_addr_i,
  input  logic [NUM_PORTS*48-1:0]     rx_mac_dst_addr_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] data_start_ptr_i,
  output logic [NUM_PORTS-1:0]        eof_ready_o,
  output logic [NUM_PORTS-1:0]        voq_write_reqs_o,
  output logic [NUM_PORTS*ADDR_W-1:0] voq_start_ptrs_o,
  input  logic [NUM_PORTS-1:0]        voq_ready_i,
  input  logic                        age_tick_i,
  output logic [15:0]                 drop_count_o
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(TABLE_DEPTH);

  typedef enum logic [1:0] {IDLE, LEARN, LOOKUP, ISSUE} state_t;
  state_t state, state_nxt;

  logic [NUM_PORTS-1:0] slot_full;
  logic [47:0]          slot_src [NUM_PORTS];
  logic [47:0]          slot_dst [NUM_PORTS];
  logic [ADDR_W-1:0]    slot_ptr [NUM_PORTS];

  logic [TABLE_DEPTH-1:0] tbl_valid;
  logic [47:0]            tbl_mac  [TABLE_DEPTH];
  logic [PW-1:0]          tbl_port [TABLE_DEPTH];
  logic [TW-1:0]          victim;

  logic [PW-1:0]        rr_next, cur, grant_idx, dst_port;
  logic [NUM_PORTS-1:0] mask, done, accept, lookup_mask;
  logic [15:0]          drop_count;
  logic [47:0]          cur_src, cur_dst;
  logic                 grant_vld, src_hit, free_vld, dst_hit, drop_hit, all_done;
  logic [TW-1:0]        src_idx, free_idx, learn_idx;

`ifdef FWD_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] tbl_age [TABLE_DEPTH];
`else
  logic unused_age_tick;
  assign unused_age_tick = age_tick_i;
`endif

  assign cur_src      = slot_src[cur];
  assign cur_dst      = slot_dst[cur];
  assign eof_ready_o  = ~slot_full;
  assign drop_count_o = drop_count;
  assign accept       = voq_write_reqs_o & voq_ready_i;
  assign all_done     = ((done | accept) & mask) == mask;
  assign learn_idx    = src_hit ? src_idx : (free_vld ? free_idx : victim);

  // rr_next holds the first port to examine, i.e. last grant + 1.
  always_comb begin
    int k;
    k         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      k = int'(rr_next) + i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (slot_full[PW'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(k);
      end
    end
  end

  always_comb begin
    src_hit  = 1'b0;
    src_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    dst_hit  = 1'b0;
    dst_port = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (tbl_valid[i] && tbl_mac[i] == cur_src) begin
        src_hit = 1'b1;
        src_idx = TW'(i);
      end
      if (!tbl_valid[i]) begin
        free_vld = 1'b1;
        free_idx = TW'(i);
      end
      if (tbl_valid[i] && tbl_mac[i] == cur_dst) begin
        dst_hit  = 1'b1;
        dst_port = tbl_port[i];
      end
    end
  end

  always_comb begin
    lookup_mask = ~(NUM_PORTS'(1) << cur);
    drop_hit    = 1'b0;
    if (!cur_dst[40] && dst_hit) begin
      if (dst_port == cur) begin
        lookup_mask = '0;
        drop_hit    = 1'b1;
      end else begin
        lookup_mask = NUM_PORTS'(1) << dst_port;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = LEARN;
      LEARN:   state_nxt = LOOKUP;
      LOOKUP:  state_nxt = (lookup_mask == '0) ? IDLE : ISSUE;
      ISSUE:   if (all_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    voq_write_reqs_o = '0;
    voq_start_ptrs_o = '0;
    if (state == ISSUE) voq_write_reqs_o = mask & ~done;
    for (int e = 0; e < NUM_PORTS; e++)
      if (voq_write_reqs_o[e]) voq_start_ptrs_o[e*ADDR_W +: ADDR_W] = slot_ptr[cur];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full  <= '0;
      tbl_valid  <= '0;
      victim     <= '0;
      rr_next    <= '0;
      cur        <= '0;
      mask       <= '0;
      done       <= '0;
      drop_count <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (eof_i[p] && !slot_full[p]) begin
          slot_full[p] <= 1'b1;
          slot_src[p]  <= rx_mac_src_addr_i[p*48 +: 48];
          slot_dst[p]  <= rx_mac_dst_addr_i[p*48 +: 48];
          slot_ptr[p]  <= data_start_ptr_i[p*ADDR_W +: ADDR_W];
        end
      end
`ifdef FWD_AGING_EN
      // Aging precedes the learn write below so a same-cycle learn wins.
      if (age_tick_i) begin
        for (int i = 0; i < TABLE_DEPTH; i++) begin
          if (tbl_valid[i]) begin
            if (int'(tbl_age[i]) >= AGE_LIMIT - 1) begin
              tbl_valid[i] <= 1'b0;
              tbl_age[i]   <= AW'(AGE_LIMIT);
            end else begin
              tbl_age[i] <= tbl_age[i] + 1'b1;
            end
          end
        end
      end
`endif
      case (state)
        IDLE: begin
          if (grant_vld) begin
            cur     <= grant_idx;
            rr_next <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        LEARN: begin
          if (!cur_src[40]) begin
            tbl_valid[learn_idx] <= 1'b1;
            tbl_mac[learn_idx]   <= cur_src;
            tbl_port[learn_idx]  <= cur;
`ifdef FWD_AGING_EN
            tbl_age[learn_idx]   <= '0;
`endif
            if (!src_hit && !free_vld) victim <= victim + 1'b1;
          end
        end
        LOOKUP: begin
          mask <= lookup_mask;
          done <= '0;
          if (lookup_mask == '0) slot_full[cur] <= 1'b0;
          if (drop_hit && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
        ISSUE: begin
          done <= done | accept;
          if (all_done) begin
            slot_full[cur] <= 1'b0;
            done           <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_forward_engine.sv
// tb/tb_forward_engine.sv - directed and randomized bench for forward_engine against a MAC-table model.
module tb_forward_engine;
`ifdef FWD_AGING_EN
  localparam int AGE = 3;
`else
  localparam int AGE = 1023;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   eof_i, eof_ready, reqs, vready;
  logic [191:0] rx_src, rx_dst;
  logic [47:0]  ptr_in, ptrs;
  logic         tick;
  logic [15:0]  drop;

  int n_cmp = 0;
  int n_err = 0;

  int          mtab [logic [47:0]];
  int          mage [logic [47:0]];
  logic [15:0] mdrop;
  logic [47:0] pool [8];

  always #5 clk = ~clk;

  forward_engine #(.NUM_PORTS(4), .ADDR_W(12), .TABLE_DEPTH(16), .AGE_LIMIT(AGE)) dut (
    .clk(clk), .rst(rst), .eof_i(eof_i),
    .rx_mac_src_addr_i(rx_src), .rx_mac_dst_addr_i(rx_dst), .data_start_ptr_i(ptr_in),
    .eof_ready_o(eof_ready), .voq_write_reqs_o(reqs), .voq_start_ptrs_o(ptrs),
    .voq_ready_i(vready), .age_tick_i(tick), .drop_count_o(drop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [47:0] src, input logic [47:0] dst,
                          input logic [11:0] ptr);
    rx_src[p*48 +: 48] = src;
    rx_dst[p*48 +: 48] = dst;
    ptr_in[p*12 +: 12] = ptr;
  endtask

  task automatic do_reset();
    rst = 1'b1; eof_i = '0; vready = '0; tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mtab.delete();
    mage.delete();
    mdrop = '0;
  endtask

  // Expected egress set for one frame, learning its source first.
  task automatic model_frame(input int ing, input logic [47:0] src, input logic [47:0] dst,
                             output logic [3:0] m);
    if (!src[40]) begin
      mtab[src] = ing;
      mage[src] = 0;
    end
    if (dst[40] || !mtab.exists(dst)) begin
      m = 4'hF & ~4'(1 << ing);
    end else if (mtab[dst] == ing) begin
      m = '0;
      if (mdrop != 16'hFFFF) mdrop++;
    end else begin
      m = 4'(1 << mtab[dst]);
    end
  endtask

  task automatic model_tick();
`ifdef FWD_AGING_EN
    logic [47:0] expired [$];
    foreach (mage[k]) begin
      mage[k]++;
      if (mage[k] >= AGE) expired.push_back(k);
    end
    foreach (expired[j]) begin
      mtab.delete(expired[j]);
      mage.delete(expired[j]);
    end
`endif
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    model_tick();
  endtask

  // mode 0: all ready; 1: egress 1 not ready for the first 5 issue cycles; 2: random ready.
  task automatic do_frame(input int p, input logic [47:0] src, input logic [47:0] dst,
                          input logic [11:0] ptr, input int mode);
    logic [3:0] m, md, er;
    int guard, n;
    guard = 0;
    while (!eof_ready[p] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("eof_ready_wait", eof_ready[p], 1'b1);
    set_port(p, src, dst, ptr);
    eof_i = 4'(1 << p);
    @(negedge clk);
    eof_i = '0;
    model_frame(p, src, dst, m);
    for (int c = 1; c <= 3; c++) begin
      check("reqs_before_issue", reqs, 4'h0);
      @(negedge clk);
    end
    if (m == 4'h0) begin
      check("zero_mask_reqs", reqs, 4'h0);
      check("zero_mask_slot_freed", eof_ready[p], 1'b1);
      check("drop_count", drop, mdrop);
    end else begin
      md = '0;
      n  = 0;
      while (md != m && n < 200) begin
        er = m & ~md;
        check("reqs", reqs, er);
        for (int e = 0; e < 4; e++)
          if (er[e]) check("req_ptr", ptrs[e*12 +: 12], ptr);
        check("slot_held", eof_ready[p], 1'b0);
        case (mode)
          0:       vready = 4'hF;
          1:       vready = (n < 5) ? 4'b1101 : 4'hF;
          default: vready = 4'($urandom);
        endcase
        md = md | (er & vready);
        n++;
        @(negedge clk);
      end
      check("issue_complete", md, m);
      check("reqs_after_issue", reqs, 4'h0);
      check("slot_freed", eof_ready[p], 1'b1);
      check("drop_count", drop, mdrop);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] s4 [4];
    logic [47:0] d4 [4];
    logic [3:0]  em [4];
    logic [3:0]  obs_m [$];
    logic [11:0] obs_p [$];
    logic [11:0] pl;

    rst = 1'b1; eof_i = '0; vready = '0; tick = 1'b0;
    rx_src = '0; rx_dst = '0; ptr_in = '0;
    for (int k = 0; k < 6; k++) pool[k] = {40'h02_00_00_00_03, 8'(k)};
    pool[6] = 48'h01_00_5E_00_00_01;
    pool[7] = 48'hFF_FF_FF_FF_FF_FF;

    do_reset();
    check("reset_eof_ready", eof_ready, 4'hF);
    check("reset_reqs", reqs, 4'h0);
    check("reset_ptrs", ptrs, 48'h0);
    check("reset_drop", drop, 16'h0);

    do_frame(0, 48'h02_00_00_00_00_0A, 48'h02_00_00_00_00_0B, 12'h010, 0);
    do_frame(2, 48'h02_00_00_00_00_0C, 48'h02_00_00_00_00_0A, 12'h020, 0);
    do_frame(0, 48'h02_00_00_00_00_0A, 48'h02_00_00_00_00_0A, 12'h025, 0);
    do_frame(3, 48'h02_00_00_00_00_0D, 48'hFF_FF_FF_FF_FF_FF, 12'h030, 1);

    // Four simultaneous eofs, plus a second port 0 eof while its slot is occupied.
    do_reset();
    for (int k = 0; k < 4; k++) s4[k] = {40'h02_00_00_00_01, 8'(k)};
    d4[0] = s4[3]; d4[1] = s4[0]; d4[2] = 48'hFF_FF_FF_FF_FF_FF; d4[3] = s4[1];
    for (int k = 0; k < 4; k++) set_port(k, s4[k], d4[k], 12'(12'h100 + k));
    vready = 4'hF;
    eof_i  = 4'hF;
    @(negedge clk);
    eof_i = '0;
    for (int k = 0; k < 4; k++) model_frame(k, s4[k], d4[k], em[k]);
    @(negedge clk);
    check("slot0_busy", eof_ready[0], 1'b0);
    set_port(0, 48'h02_00_00_00_01_09, 48'hFF_FF_FF_FF_FF_FF, 12'h0FF);
    eof_i = 4'b0001;
    @(negedge clk);
    eof_i = '0;
    for (int c = 0; c < 60; c++) begin
      if (reqs != 4'h0) begin
        pl = '0;
        for (int e = 3; e >= 0; e--) if (reqs[e]) pl = ptrs[e*12 +: 12];
        obs_m.push_back(reqs);
        obs_p.push_back(pl);
      end
      @(negedge clk);
    end
    check("order_count", obs_m.size(), 4);
    for (int k = 0; k < 4 && k < obs_m.size(); k++) begin
      check("order_mask", obs_m[k], em[k]);
      check("order_ptr", obs_p[k], 12'(12'h100 + k));
    end
    check("all_slots_free", eof_ready, 4'hF);

    // Aging: A survives two ticks, disappears on the third only when aging is built in.
    do_reset();
    do_frame(1, 48'h02_00_00_00_02_01, 48'h02_00_00_00_02_02, 12'h051, 0);
    tick_pulse();
    tick_pulse();
    do_frame(0, 48'h02_00_00_00_02_02, 48'h02_00_00_00_02_01, 12'h052, 0);
    tick_pulse();
    do_frame(2, 48'h02_00_00_00_02_03, 48'h02_00_00_00_02_01, 12'h053, 0);

    // Reset in the middle of an issue drops the frame.
    do_reset();
    vready = '0;
    set_port(1, 48'h02_00_00_00_00_04, 48'hFF_FF_FF_FF_FF_FF, 12'h040);
    eof_i = 4'b0010;
    @(negedge clk);
    eof_i = '0;
    repeat (3) @(negedge clk);
    check("rst_issue_live", reqs, 4'b1101);
    rst = 1'b1;
    @(negedge clk);
    check("rst_issue_reqs", reqs, 4'h0);
    check("rst_issue_slots", eof_ready, 4'hF);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_reqs", reqs, 4'h0);
    end

    do_reset();
    for (int f = 0; f < 40; f++)
      do_frame(int'($urandom_range(0, 3)), pool[$urandom_range(0, 6)], pool[$urandom_range(0, 7)],
               12'($urandom), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/forward_engine.md
FORWARD_ENGINE -- requirements
Module: forward_engine

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of switch ports; legal range 2 to 16.
REQ-002 SHALL have parameter ADDR_W, default 12, packet-buffer pointer width.
REQ-003 SHALL have parameter TABLE_DEPTH, default 16, number of MAC table entries; legal values are powers of 2, 2 or greater.
REQ-004 SHALL have parameter AGE_LIMIT, default 1023, age ticks before an entry expires.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port eof_i, input, NUM_PORTS bits: per-ingress end-of-frame strobe.
REQ-008 SHALL have port rx_mac_src_addr_i, input, NUM_PORTS x 48 bits: source MAC per ingress port.
REQ-009 SHALL have port rx_mac_dst_addr_i, input, NUM_PORTS x 48 bits: destination MAC per ingress port.
REQ-010 SHALL have port data_start_ptr_i, input, NUM_PORTS x ADDR_W bits: frame start pointer per ingress port.
REQ-011 SHALL have port eof_ready_o, output, NUM_PORTS bits: capture slot free.
REQ-012 SHALL have port voq_write_reqs_o, output, NUM_PORTS bits: per-egress VOQ write request.
REQ-013 SHALL have port voq_start_ptrs_o, output, NUM_PORTS x ADDR_W bits: pointer presented with each request.
REQ-014 SHALL have port voq_ready_i, input, NUM_PORTS bits: VOQ accepts the request this cycle.
REQ-015 SHALL have port age_tick_i, input, 1 bit: aging strobe.
REQ-016 SHALL have port drop_count_o, output, 16 bits: count of filtered frames.

Function
REQ-017 SHALL capture src, dst and ptr into slot p when eof_i[p] and eof_ready_o[p] are both 1; eof_ready_o[p] SHALL equal NOT slot_full[p], and eof_i[p] while the slot is full SHALL be ignored.
REQ-018 SHALL, in IDLE, grant one full slot round-robin, searching from (last grant + 1) mod NUM_PORTS.
REQ-019 SHALL run the FSM IDLE -> LEARN -> LOOKUP -> ISSUE -> IDLE, one cycle per state except ISSUE; IDLE SHALL advance only when a grant is made.
REQ-020 LEARN SHALL, on a source hit, overwrite the entry's port; on a miss, write the lowest-index invalid entry; if the table is full, replace the entry at the victim pointer, then increment the victim pointer (wraps).
REQ-021 LEARN SHALL skip any source with bit 40 = 1 (group address).
REQ-022 LOOKUP SHALL compute the egress mask:
  - dst bit 40 = 1 (multicast or broadcast): all ports except ingress.
  - dst hit on port q, q != ingress: one-hot q.
  - dst hit on port q, q == ingress: 0, and drop_count_o increments.
  - dst miss: all ports except ingress.
REQ-023 LOOKUP SHALL see the table as updated by LEARN of the same frame.
REQ-024 ISSUE SHALL drive voq_write_reqs_o = mask AND NOT done, with voq_start_ptrs_o[e] = frame ptr on every requested egress e.
REQ-025 A request SHALL hold with a stable pointer until voq_ready_i[e]; a request/ready cycle SHALL set done[e].
REQ-026 ISSUE SHALL exit to IDLE in the cycle after all mask bits are done, clearing the slot and deasserting all requests. A zero mask SHALL skip ISSUE and free the slot at the end of LOOKUP.
REQ-027 Latency: eof accepted in cycle N, idle engine, no other slot full -> requests visible in cycle N+4; freed slot's eof_ready_o = 1 in the cycle after the last accept.
REQ-028 drop_count_o SHALL saturate at 0xFFFF.
REQ-029 An eof on the slot being freed in the same cycle SHALL NOT be accepted; eof_ready_o governs.

Reset
REQ-030 While rst = 1 on a clock edge, the block SHALL reset to:
  - all table entries invalid;
  - all slots empty (eof_ready_o = all 1);
  - FSM = IDLE;
  - round-robin and victim pointers = 0;
  - voq_write_reqs_o = 0, voq_start_ptrs_o = 0, drop_count_o = 0;
  - done = 0.
REQ-031 A reset during ISSUE SHALL drop the in-flight frame with no further requests.

Configuration
REQ-032 Macro FWD_AGING_EN defined: each entry SHALL carry an age counter.
  - Learn hit or write: age cleared to 0.
  - age_tick_i = 1: every valid entry's age increments, saturating.
  - Valid entry whose age reaches AGE_LIMIT: invalidated on that tick.
  - Learn and tick on the same entry in the same cycle: learn wins.
REQ-033 FWD_AGING_EN undefined: age_tick_i SHALL be ignored, no age storage SHALL exist, and entries SHALL persist until replaced or reset.

Verification
REQ-034 Cold table, port 0 eof, src 02:00:00:00:00:0A, dst 02:00:00:00:00:0B, ptr 0x010, all ready -> reqs = 4'b1110 with ptr 0x010 at N+4, then port 0 learned.
REQ-035 Then port 2 eof, dst 02:00:00:00:00:0A, ptr 0x020 -> reqs = 4'b0001, ptr 0x020, single cycle.
REQ-036 Port 0 eof, dst 02:00:00:00:00:0A (learned on port 0) -> no requests, drop_count_o = 1, slot freed.
REQ-037 dst FF:FF:FF:FF:FF:FF from port 3, voq_ready_i[1] held 0 for 5 cycles -> req[1] held with a stable pointer, req[0] and req[2] drop after accept, slot 3 freed only after egress 1 accepts.
REQ-038 Ports 0-3 eof in the same cycle -> serviced in order 0, 1, 2, 3; a second eof on port 0 while its slot is full is ignored.
REQ-039 FWD_AGING_EN defined, AGE_LIMIT = 3, entry learned then 3 age_tick_i -> next lookup of that MAC floods 3 ports.
